alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Initiator side of the alu32 datapath interface. Accepts one ALU request
//  (op, operands, shamt) over a valid/ready handshake and drives alu32's
//  srca/srcb/alucontrol/shamt inputs. Runs SRL/SRA as N single-bit passes,
//  because alu32 shifts right by 1 only. Captures aluout/zero and returns them
//  over a valid/ready response port. Sits between the multicycle control and alu32.
// PARAMETERS
//  WIDTH  32  datapath width; must match alu32
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      synchronous, active-high
//  req_valid    in   1      request present
//  req_ready    out  1      sequencer can accept a request
//  req_op       in   4      op in alucontrol encoding (bit3 = SUB/arith)
//  req_a        in   WIDTH  operand A
//  req_b        in   WIDTH  operand B
//  req_shamt    in   5      shift amount
//  alu_srca     out  WIDTH  to alu32 srca
//  alu_srcb     out  WIDTH  to alu32 srcb
//  alu_control  out  4      to alu32 alucontrol
//  alu_shamt    out  5      to alu32 shamt
//  alu_result   in   WIDTH  from alu32 aluout
//  alu_zero     in   1      from alu32 zero
//  rsp_valid    out  1      response present
//  rsp_ready    in   1      consumer accepts response
//  rsp_result   out  WIDTH  result
//  rsp_zero     out  1      captured alu_zero (0 for shifts and errors)
//  rsp_err      out  1      op not supported
// BEHAVIOUR
//  - FSM states: IDLE, ISSUE, SHIFT, RESP. Reset (sync) forces IDLE and discards any
//    in-flight op, including mid-SHIFT. After reset: rsp_valid/result/zero/err = 0,
//    and all alu_* outputs = 0.
//  - req_ready = (state==IDLE). A handshake is req_valid&req_ready at a rising edge.
//    On a handshake, latch op, a, b and shamt.
//  - Op classes, decided on the latched op:
//    single (000 ADD, 1000 SUB, x001 SLL, x010 SLT, x100, x110, x111):
//      IDLE->ISSUE->RESP.
//    SRL (0101) and SRA (1101, macro only): IDLE->SHIFT, or IDLE->RESP if shamt==0.
//    illegal (x011 SLTU; 1101 without macro): IDLE->RESP with rsp_err=1, result=0.
//  - ISSUE (1 cycle): alu_srca=a, alu_srcb=b, alu_control=op, alu_shamt=shamt.
//    At the edge, capture alu_result -> rsp_result and alu_zero -> rsp_zero.
//  - SHIFT: acc is initialised to a and cnt to shamt.
//    Each cycle: alu_srca=acc, alu_control=4'b0101.
//    At each edge: acc <= alu_result, with bit WIDTH-1 forced to acc[WIDTH-1] when SRA.
//    cnt decrements; when cnt reaches 1, go to RESP with result=acc.
//    shamt==0 gives result=a. rsp_zero=0.
//  - Outside ISSUE/SHIFT, all alu_* outputs = 0.
//  - Latency (handshake edge T): single op -> rsp_valid after edge T+1.
//    Shift by n>0 -> after edge T+n. n==0 or illegal -> after edge T.
//  - RESP: rsp_valid=1. result/zero/err stay stable until rsp_valid&rsp_ready.
//    That edge returns to IDLE and clears rsp_valid.
//    No new request is accepted in the completing cycle (req_ready=0 in RESP).
//  - Backpressure of any length is allowed. No response is ever dropped or duplicated.
// CONFIGURATION
//  SEQ_SRA_EN defined: op 1101 = arithmetic right shift by shamt (sign fill).
//  Not defined: op 1101 is illegal -> rsp_err=1, rsp_result=0. All other behaviour
//  is identical.
// TESTING (bench instantiates alu32 behind the sequencer)
//  1 ADD op=0000 a=5 b=7 -> rsp_result=12, rsp_zero=0, rsp_valid after edge T+1.
//  2 SUB op=1000 a=9 b=9 -> rsp_result=0, rsp_zero=1.
//    SLT op=0010 a=-1 b=1 -> rsp_result=1.
//  3 SRL op=0101 a=32'h8000_0000 shamt=4 -> 32'h0800_0000 after edge T+4.
//    Same op with shamt=0 -> 32'h8000_0000 after edge T.
//  4 SRA op=1101 a=32'h8000_0000 shamt=4:
//    with SEQ_SRA_EN -> 32'hF800_0000, rsp_err=0; without -> rsp_err=1, result=0.
//    SLTU op=0011 -> rsp_err=1.
//  5 Hold rsp_ready=0 for 3 cycles after rsp_valid:
//    result stays stable, req_ready=0, and the second queued request is not accepted
//    until the cycle after the handshake.
//  6 Assert reset for 1 cycle mid-SHIFT (shamt=20, cycle 5):
//    next cycle state=IDLE, rsp_valid=0, alu_*=0, req_ready=1, and no stale response.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Request/response front end for alu32: issues single ops in one cycle and runs
// right shifts as repeated 1-bit passes. Define SEQ_SRA_EN to enable op 1101 (SRA).
module alu_op_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       req_op_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  input  logic [4:0]       req_shamt_i,
  output logic [WIDTH-1:0] alu_srca_o,
  output logic [WIDTH-1:0] alu_srcb_o,
  output logic [3:0]       alu_control_o,
  output logic [4:0]       alu_shamt_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_zero_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_zero_o,
  output logic             rsp_err_o
);

`ifdef SEQ_SRA_EN
  localparam bit SraEn = 1'b1;
`else
  localparam bit SraEn = 1'b0;
`endif

  localparam logic [3:0] OpSrl = 4'b0101;
  localparam logic [3:0] OpSra = 4'b1101;

  typedef enum logic [1:0] {StIdle, StIssue, StShift, StResp} state_e;

  state_e           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [4:0]       shamt_q;
  logic [WIDTH-1:0] acc_q;
  logic [4:0]       cnt_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q;
  logic             rsp_err_q;

  logic             req_is_shift;
  logic             req_is_illegal;
  logic [WIDTH-1:0] shift_next;

  always_comb begin
    req_is_shift   = (req_op_i == OpSrl) || (SraEn && (req_op_i == OpSra));
    req_is_illegal = (req_op_i[2:0] == 3'b011) || (!SraEn && (req_op_i == OpSra));
  end

  // alu32 only does a logical 1-bit right shift; SRA restores the sign bit here.
  always_comb begin
    shift_next          = alu_result_i;
    shift_next[WIDTH-1] = op_q[3] ? acc_q[WIDTH-1] : alu_result_i[WIDTH-1];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      shamt_q      <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            op_q       <= req_op_i;
            a_q        <= req_a_i;
            b_q        <= req_b_i;
            shamt_q    <= req_shamt_i;
            acc_q      <= req_a_i;
            cnt_q      <= req_shamt_i;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            if (req_is_illegal) begin
              rsp_result_q <= '0;
              rsp_err_q    <= 1'b1;
              rsp_valid_q  <= 1'b1;
              state_q      <= StResp;
            end else if (req_is_shift) begin
              if (req_shamt_i == 5'd0) begin
                rsp_result_q <= req_a_i;
                rsp_valid_q  <= 1'b1;
                state_q      <= StResp;
              end else begin
                state_q <= StShift;
              end
            end else begin
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          rsp_result_q <= alu_result_i;
          rsp_zero_q   <= alu_zero_i;
          rsp_valid_q  <= 1'b1;
          state_q      <= StResp;
        end
        StShift: begin
          acc_q <= shift_next;
          if (cnt_q == 5'd1) begin
            rsp_result_q <= shift_next;
            rsp_valid_q  <= 1'b1;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    alu_srca_o    = '0;
    alu_srcb_o    = '0;
    alu_control_o = 4'b0000;
    alu_shamt_o   = 5'd0;
    if (state_q == StIssue) begin
      alu_srca_o    = a_q;
      alu_srcb_o    = b_q;
      alu_control_o = op_q;
      alu_shamt_o   = shamt_q;
    end else if (state_q == StShift) begin
      alu_srca_o    = acc_q;
      alu_control_o = OpSrl;
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural alu32 behind it.
// Expectations for op 1101 follow SEQ_SRA_EN.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [4:0]  req_shamt = 5'd0;
  logic [31:0] alu_srca;
  logic [31:0] alu_srcb;
  logic [3:0]  alu_control;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(32)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_op_i      (req_op),
    .req_a_i       (req_a),
    .req_b_i       (req_b),
    .req_shamt_i   (req_shamt),
    .alu_srca_o    (alu_srca),
    .alu_srcb_o    (alu_srcb),
    .alu_control_o (alu_control),
    .alu_shamt_o   (alu_shamt),
    .alu_result_i  (alu_result),
    .alu_zero_i    (alu_zero),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_result_o  (rsp_result),
    .rsp_zero_o    (rsp_zero),
    .rsp_err_o     (rsp_err)
  );

  // Behavioural alu32: right shift is by one only.
  always_comb begin
    unique case (alu_control[2:0])
      3'b000:  alu_result = alu_control[3] ? alu_srca - alu_srcb : alu_srca + alu_srcb;
      3'b001:  alu_result = alu_srca << alu_shamt;
      3'b010:  alu_result = {31'd0, $signed(alu_srca) < $signed(alu_srcb)};
      3'b011:  alu_result = {31'd0, alu_srca < alu_srcb};
      3'b100:  alu_result = alu_srca ^ alu_srcb;
      3'b101:  alu_result = alu_srca >> 1;
      3'b110:  alu_result = alu_srca | alu_srcb;
      default: alu_result = alu_srca & alu_srcb;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  // Called #1 after an edge with the sequencer idle; lat counts edges after handshake.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output int lat, output logic [31:0] srca_obs,
                       output logic [3:0] ctrl_obs);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_shamt = sh;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    srca_obs  = alu_srca;
    ctrl_obs  = alu_control;
    lat       = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0)
    begin
      errors++;
      $display("FAIL reset_rsp got v=%b r=%h z=%b e=%b exp all 0", rsp_valid, rsp_result,
               rsp_zero, rsp_err);
    end
    checks++;
    if (alu_srca !== 32'd0 || alu_srcb !== 32'd0 || alu_control !== 4'd0 ||
        alu_shamt !== 5'd0) begin
      errors++;
      $display("FAIL reset_alu got a=%h b=%h c=%h s=%h exp 0", alu_srca, alu_srcb,
               alu_control, alu_shamt);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_single();
    int lat;
    logic [31:0] sa;
    logic [3:0] sc;
    issue(4'b0000, 32'd5, 32'd7, 5'd0, lat, sa, sc);
    checks++;
    if (sa !== 32'd5 || sc !== 4'b0000) begin
      errors++;
      $display("FAIL add_issue got srca=%h ctrl=%h exp 5 0", sa, sc);
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL add_latency got %0d exp 1", lat);
    end
    checks++;
    if (rsp_result !== 32'd12 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL add_result got r=%h z=%b e=%b exp 0000000c 0 0", rsp_result, rsp_zero,
               rsp_err);
    end
    take();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_complete got v=%b rdy=%b exp 0 1", rsp_valid, req_ready);
    end

    issue(4'b1000, 32'd9, 32'd9, 5'd0, lat, sa, sc);
    checks++;
    if (rsp_result !== 32'd0 || rsp_zero !== 1'b1 || lat !== 1) begin
      errors++;
      $display("FAIL sub_result got r=%h z=%b lat=%0d exp 0 1 1", rsp_result, rsp_zero, lat);
    end
    take();

    issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd0, lat, sa, sc);
    checks++;
    if (rsp_result !== 32'd1 || rsp_zero !== 1'b0) begin
      errors++;
      $display("FAIL slt_result got r=%h z=%b exp 1 0", rsp_result, rsp_zero);
    end
    take();

    issue(4'b0111, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0, lat, sa, sc);
    checks++;
    if (rsp_result !== 32'h00F0_0034) begin
      errors++;
      $display("FAIL and_result got %h exp 00f00034", rsp_result);
    end
    take();

    issue(4'b0001, 32'h0000_0003, 32'd0, 5'd4, lat, sa, sc);
    checks++;
    if (rsp_result !== 32'h0000_0030 || lat !== 1) begin
      errors++;
      $display("FAIL sll_result got r=%h lat=%0d exp 00000030 1", rsp_result, lat);
    end
    take();
  endtask

  task automatic test_shift();
    int lat;
    logic [31:0] sa;
    logic [3:0] sc;
    issue(4'b0101, 32'h8000_0000, 32'd0, 5'd4, lat, sa, sc);
    checks++;
    if (sa !== 32'h8000_0000 || sc !== 4'b0101) begin
      errors++;
      $display("FAIL srl_issue got srca=%h ctrl=%h exp 80000000 5", sa, sc);
    end
    checks++;
    if (rsp_result !== 32'h0800_0000 || lat !== 4 || rsp_zero !== 1'b0 || rsp_err !== 1'b0)
    begin
      errors++;
      $display("FAIL srl4 got r=%h lat=%0d z=%b e=%b exp 08000000 4 0 0", rsp_result, lat,
               rsp_zero, rsp_err);
    end
    take();

    issue(4'b0101, 32'h8000_0000, 32'd0, 5'd0, lat, sa, sc);
    checks++;
    if (rsp_result !== 32'h8000_0000 || lat !== 0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL srl0 got r=%h lat=%0d e=%b exp 80000000 0 0", rsp_result, lat, rsp_err);
    end
    take();

    issue(4'b0101, 32'h8000_0001, 32'd0, 5'd1, lat, sa, sc);
    checks++;
    if (rsp_result !== 32'h4000_0000 || lat !== 1) begin
      errors++;
      $display("FAIL srl1 got r=%h lat=%0d exp 40000000 1", rsp_result, lat);
    end
    take();

    // Result of zero from a shift still reports rsp_zero=0.
    issue(4'b0101, 32'h0000_0001, 32'd0, 5'd4, lat, sa, sc);
    checks++;
    if (rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin
      errors++;
      $display("FAIL srl_to_zero got r=%h z=%b exp 0 0", rsp_result, rsp_zero);
    end
    take();
  endtask

  task automatic test_sra_illegal();
    int lat;
    logic [31:0] sa;
    logic [3:0] sc;
    issue(4'b1101, 32'h8000_0000, 32'd0, 5'd4, lat, sa, sc);
`ifdef SEQ_SRA_EN
    checks++;
    if (rsp_result !== 32'hF800_0000 || rsp_err !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL sra4 got r=%h e=%b lat=%0d exp f8000000 0 4", rsp_result, rsp_err, lat);
    end
`else
    checks++;
    if (rsp_result !== 32'd0 || rsp_err !== 1'b1 || lat !== 0) begin
      errors++;
      $display("FAIL sra_illegal got r=%h e=%b lat=%0d exp 0 1 0", rsp_result, rsp_err, lat);
    end
`endif
    take();

    issue(4'b0011, 32'd1, 32'd2, 5'd0, lat, sa, sc);
    checks++;
    if (rsp_err !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b0 || lat !== 0) begin
      errors++;
      $display("FAIL sltu_illegal got e=%b r=%h z=%b lat=%0d exp 1 0 0 0", rsp_err, rsp_result,
               rsp_zero, lat);
    end
    take();

    // Error flag must not leak into the next legal op.
    issue(4'b0110, 32'h0000_00F0, 32'h0000_000F, 5'd0, lat, sa, sc);
    checks++;
    if (rsp_err !== 1'b0 || rsp_result !== 32'h0000_00FF) begin
      errors++;
      $display("FAIL or_after_err got e=%b r=%h exp 0 000000ff", rsp_err, rsp_result);
    end
    take();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] sa;
    logic [3:0] sc;
    issue(4'b0000, 32'd1, 32'd2, 5'd0, lat, sa, sc);
    // Second request queued while the first response is held.
    req_op    = 4'b0000;
    req_a     = 32'd10;
    req_b     = 32'd20;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'd3 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d got v=%b r=%h rdy=%b exp 1 00000003 0", i, rsp_valid,
                 rsp_result, req_ready);
      end
    end
    take();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release got v=%b rdy=%b exp 0 1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || alu_srca !== 32'd10) begin
      errors++;
      $display("FAIL second_accept got rdy=%b srca=%h exp 0 0000000a", req_ready, alu_srca);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd30) begin
      errors++;
      $display("FAIL second_result got v=%b r=%h exp 1 0000001e", rsp_valid, rsp_result);
    end
    take();
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    int lat;
    logic [31:0] sa;
    logic [3:0] sc;
    req_op    = 4'b0101;
    req_a     = 32'hFFFF_FFFF;
    req_shamt = 5'd20;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state got v=%b rdy=%b exp 0 1", rsp_valid, req_ready);
    end
    checks++;
    if (alu_srca !== 32'd0 || alu_control !== 4'd0 || alu_srcb !== 32'd0 ||
        alu_shamt !== 5'd0) begin
      errors++;
      $display("FAIL midreset_alu got a=%h c=%h exp 0 0", alu_srca, alu_control);
    end
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_stale got %0d valid cycles exp 0", seen);
    end
    issue(4'b0100, 32'hAAAA_0000, 32'hFFFF_0000, 5'd0, lat, sa, sc);
    checks++;
    if (rsp_result !== 32'h5555_0000 || lat !== 1) begin
      errors++;
      $display("FAIL midreset_recover got r=%h lat=%0d exp 55550000 1", rsp_result, lat);
    end
    take();
  endtask

  initial begin
    test_reset();
    test_single();
    test_shift();
    test_sra_illegal();
    test_back_to_back();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
